// File: rtl/pc_unit.sv
// pc_unit: program counter with branch/jump/call/return sources,
// exception entry/eret, misaligned jump-reg trap and a return stack.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   en, sel           PC write strobe, next-PC source select
//   offset, target    branch word offset, absolute target
//   exc, eret         exception request, return from exception
//   curr_pc, epc      current PC, saved exception PC
//   ras_empty/full    return stack occupancy flags
//   misalign          pulse: jump-reg target misaligned
//   ras_underflow     pulse: return with empty stack
module pc_unit #(
   parameter int WIDTH = 32,
   parameter logic [WIDTH-1:0] RESET_PC = '0,
   parameter logic [31:0] EXC_VEC = 32'h0000_0180,
   parameter int STEP = 4,
   parameter int RAS_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [2:0]       sel,
   input  logic [WIDTH-1:0] offset,
   input  logic [WIDTH-1:0] target,
   input  logic             exc,
   input  logic             eret,
   output logic [WIDTH-1:0] curr_pc,
   output logic [WIDTH-1:0] epc,
   output logic             ras_empty,
   output logic             ras_full,
   output logic             misalign,
   output logic             ras_underflow
);

   localparam int PW = $clog2(RAS_DEPTH);
   localparam int CW = $clog2(RAS_DEPTH + 1);
   localparam logic [WIDTH-1:0] EXC_PC = WIDTH'(EXC_VEC);
   localparam logic [CW-1:0] FULL_CNT = CW'(RAS_DEPTH);

   logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
   logic [PW-1:0]    ptr;
   logic [PW-1:0]    ptr_inc;
   logic [CW-1:0]    cnt;

   logic [WIDTH-1:0] seq_pc;
   logic [WIDTH-1:0] br_pc;
   logic [WIDTH-1:0] pc_nxt;
   logic [WIDTH-1:0] epc_nxt;
   logic             push;
   logic             pop;
   logic             mis_nxt;
   logic             unf_nxt;

   logic sel_br;
   logic sel_jmp;
   logic sel_jr;
   logic sel_call;
   logic sel_ret;

   assign seq_pc  = curr_pc + WIDTH'(STEP);
   assign br_pc   = seq_pc + (offset << 2);
   assign ptr_inc = ptr + PW'(1);

   assign sel_br   = (sel == 3'd1);
   assign sel_jmp  = (sel == 3'd2);
   assign sel_jr   = (sel == 3'd3);
   assign sel_call = (sel == 3'd4);
   assign sel_ret  = (sel == 3'd5);

   assign ras_empty = (cnt == '0);
   assign ras_full  = (cnt == FULL_CNT);

   always_comb begin
      pc_nxt  = curr_pc;
      epc_nxt = epc;
      push    = 1'b0;
      pop     = 1'b0;
      mis_nxt = 1'b0;
      unf_nxt = 1'b0;
      if (exc) begin
         epc_nxt = curr_pc;
         pc_nxt  = EXC_PC;
      end else if (eret) begin
         pc_nxt = epc;
      end else if (en) begin
         unique case (1'b1)
            sel_br:  pc_nxt = br_pc;
            sel_jmp: pc_nxt = target;
            sel_jr: begin
               if (target[1:0] != 2'b00) begin
                  epc_nxt = curr_pc;
                  pc_nxt  = EXC_PC;
                  mis_nxt = 1'b1;
               end else begin
                  pc_nxt = target;
               end
            end
            sel_call: begin
               pc_nxt = target;
               push   = 1'b1;
            end
            sel_ret: begin
               if (ras_empty) begin
                  pc_nxt  = seq_pc;
                  unf_nxt = 1'b1;
               end else begin
                  pc_nxt = ras_mem[ptr];
                  pop    = 1'b1;
               end
            end
            default: pc_nxt = seq_pc;
         endcase
      end
   end

   // ptr names the top entry; a push when full wraps onto
   // the oldest slot, which drops the deepest return address.
   always_ff @(posedge clk) begin
      if (rst) begin
         curr_pc       <= RESET_PC;
         epc           <= '0;
         ptr           <= '0;
         cnt           <= '0;
         misalign      <= 1'b0;
         ras_underflow <= 1'b0;
      end else begin
         curr_pc       <= pc_nxt;
         epc           <= epc_nxt;
         misalign      <= mis_nxt;
         ras_underflow <= unf_nxt;
         if (push) begin
            ras_mem[ptr_inc] <= seq_pc;
            ptr              <= ptr_inc;
            if (!ras_full) cnt <= cnt + CW'(1);
         end else if (pop) begin
            ptr <= ptr - PW'(1);
            cnt <= cnt - CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed scoreboard bench for pc_unit.
// Driver queues expected state; a negedge monitor checks it.
module tb_pc_unit;

   logic        clk;
   logic        rst;
   logic        en;
   logic [2:0]  sel;
   logic [31:0] offset;
   logic [31:0] target;
   logic        exc;
   logic        eret;
   logic [31:0] curr_pc;
   logic [31:0] epc;
   logic        ras_empty;
   logic        ras_full;
   logic        misalign;
   logic        ras_underflow;

   int checks = 0;
   int errors = 0;
   int step_no = 0;

   typedef struct {
      int          id;
      logic [31:0] pc;
      logic [31:0] epc;
      logic [3:0]  fl;
   } exp_t;

   exp_t sb[$];

   pc_unit #(
      .WIDTH(32),
      .RESET_PC(32'h0),
      .EXC_VEC(32'h0000_0180),
      .STEP(4),
      .RAS_DEPTH(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .en(en),
      .sel(sel),
      .offset(offset),
      .target(target),
      .exc(exc),
      .eret(eret),
      .curr_pc(curr_pc),
      .epc(epc),
      .ras_empty(ras_empty),
      .ras_full(ras_full),
      .misalign(misalign),
      .ras_underflow(ras_underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int id,
                      input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s step %0d: got %h want %h",
                  nm, id, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (sb.size() != 0) begin
         exp_t ev;
         ev = sb.pop_front();
         chk("curr_pc", ev.id, curr_pc, ev.pc);
         chk("epc", ev.id, epc, ev.epc);
         chk("ras_empty", ev.id, 32'(ras_empty), 32'(ev.fl[3]));
         chk("ras_full", ev.id, 32'(ras_full), 32'(ev.fl[2]));
         chk("misalign", ev.id, 32'(misalign), 32'(ev.fl[1]));
         chk("ras_underflow", ev.id,
             32'(ras_underflow), 32'(ev.fl[0]));
      end
   end

   // fl = {ras_empty, ras_full, misalign, ras_underflow}
   task automatic step(input logic r, input logic e,
                       input logic [2:0] s,
                       input logic [31:0] off,
                       input logic [31:0] tgt,
                       input logic x, input logic er,
                       input logic [31:0] xp,
                       input logic [31:0] xe,
                       input logic [3:0] fl);
      exp_t ev;
      rst    = r;
      en     = e;
      sel    = s;
      offset = off;
      target = tgt;
      exc    = x;
      eret   = er;
      @(posedge clk);
      #1;
      step_no++;
      ev.id  = step_no;
      ev.pc  = xp;
      ev.epc = xe;
      ev.fl  = fl;
      sb.push_back(ev);
   endtask

   localparam logic [2:0] SQ = 3'd0;
   localparam logic [2:0] BR = 3'd1;
   localparam logic [2:0] JP = 3'd2;
   localparam logic [2:0] JR = 3'd3;
   localparam logic [2:0] CL = 3'd4;
   localparam logic [2:0] RT = 3'd5;

   initial begin
      rst = 1'b1; en = 1'b0; sel = SQ;
      offset = '0; target = '0; exc = 1'b0; eret = 1'b0;
      // reset and sequential stepping
      step(1,0,SQ,0,0,0,0, 32'h0,   32'h0, 4'b1000);
      step(1,1,CL,0,32'h50,1,0, 32'h0, 32'h0, 4'b1000);
      step(0,1,SQ,0,0,0,0, 32'h4,   32'h0, 4'b1000);
      step(0,1,SQ,0,0,0,0, 32'h8,   32'h0, 4'b1000);
      step(0,1,7,0,0,0,0,  32'hC,   32'h0, 4'b1000);
      // branch, jump, hold, wrap
      step(0,1,JP,0,32'h10,0,0, 32'h10, 32'h0, 4'b1000);
      step(0,1,BR,32'hFFFF_FFFE,0,0,0, 32'hC, 32'h0, 4'b1000);
      step(0,1,JP,0,32'h400,0,0, 32'h400, 32'h0, 4'b1000);
      step(0,0,SQ,0,0,0,0, 32'h400, 32'h0, 4'b1000);
      step(0,0,CL,5,32'h88,0,0, 32'h400, 32'h0, 4'b1000);
      step(0,1,JP,0,32'hFFFF_FFFC,0,0,
           32'hFFFF_FFFC, 32'h0, 4'b1000);
      step(0,1,BR,0,0,0,0, 32'h0, 32'h0, 4'b1000);
      step(0,1,BR,32'h3,0,0,0, 32'h10, 32'h0, 4'b1000);
      // exception / eret and priority
      step(0,1,JP,0,32'h20,0,0, 32'h20, 32'h0, 4'b1000);
      step(0,0,SQ,0,0,1,0, 32'h180, 32'h20, 4'b1000);
      step(0,0,SQ,0,0,1,1, 32'h180, 32'h180, 4'b1000);
      step(0,1,JP,0,32'h24,0,0, 32'h24, 32'h180, 4'b1000);
      step(0,1,CL,0,32'h500,1,0, 32'h180, 32'h24, 4'b1000);
      step(0,1,JP,0,32'h999,0,1, 32'h24, 32'h24, 4'b1000);
      // misaligned jump-reg
      step(0,1,JP,0,32'h30,0,0, 32'h30, 32'h24, 4'b1000);
      step(0,1,JR,0,32'h102,0,0, 32'h180, 32'h30, 4'b1010);
      step(0,1,JR,0,32'h100,0,0, 32'h100, 32'h30, 4'b1000);
      // RAS nesting and overflow
      step(0,1,JP,0,32'h0,0,0, 32'h0, 32'h30, 4'b1000);
      step(0,1,CL,0,32'h100,0,0, 32'h100, 32'h30, 4'b0000);
      step(0,1,CL,0,32'h200,0,0, 32'h200, 32'h30, 4'b0000);
      step(0,1,CL,0,32'h300,0,0, 32'h300, 32'h30, 4'b0000);
      step(0,1,CL,0,32'h400,0,0, 32'h400, 32'h30, 4'b0100);
      step(0,1,CL,0,32'h500,0,0, 32'h500, 32'h30, 4'b0100);
      step(0,1,RT,0,0,0,0, 32'h404, 32'h30, 4'b0000);
      step(0,1,RT,0,0,0,0, 32'h304, 32'h30, 4'b0000);
      step(0,1,RT,0,0,0,0, 32'h204, 32'h30, 4'b0000);
      step(0,1,RT,0,0,0,0, 32'h104, 32'h30, 4'b1000);
      step(0,1,RT,0,0,0,0, 32'h108, 32'h30, 4'b1001);
      step(0,1,SQ,0,0,0,0, 32'h10C, 32'h30, 4'b1000);
      // reset during a return discards the pop
      step(0,1,CL,0,32'h600,0,0, 32'h600, 32'h30, 4'b0000);
      step(0,1,CL,0,32'h700,0,0, 32'h700, 32'h30, 4'b0000);
      step(1,1,RT,0,0,0,0, 32'h0, 32'h0, 4'b1000);
      step(0,1,RT,0,0,0,0, 32'h4, 32'h0, 4'b1001);
      en = 1'b0;
      sel = SQ;
      repeat (3) @(posedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, want 0",
                  sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
